// File: rtl/versatile_fifo_sc_ram_ctrl.sv
// versatile_fifo_sc_ram_ctrl
//
// Single-clock FIFO controller for an external two-port RAM (port A writes,
// port B reads). It owns the write/read pointers and the level tracking. RAM
// words are prefetched into a 2-entry first-word-fall-through output stage,
// which hides the RAM's 1-cycle registered read latency.
//
// Optional feature macro: VERSATILE_FIFO_ALMOST_FLAGS_EN
//   defined   -> almost_full / almost_empty are registered threshold flags
//   undefined -> both flags are tied to 0
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_data/wr_valid/wr_ready   producer handshake
//   rd_data/rd_valid/rd_ready   consumer handshake (registered output stage)
//   fill_count                  total words held (RAM + in flight + stage)
//   almost_full, almost_empty   optional threshold flags
//   ram_adr_a/ram_d_a/ram_we_a  RAM write port
//   ram_adr_b/ram_we_b/ram_q_b  RAM read port (ram_we_b is always 0)
module versatile_fifo_sc_ram_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned AFULL_LEVEL  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH+1:0] fill_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam int unsigned CntW = ADDR_WIDTH + 2;
  localparam logic [PtrW-1:0] Depth = PtrW'(2**ADDR_WIDTH);

  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] ent_q [2];
  logic [DATA_WIDTH-1:0] ent_d [2];
  logic [CntW-1:0]       fill_q, fill_d;

  logic [PtrW-1:0] ram_level;
  logic            push, pop, issue, tail_idx;
  logic [2:0]      stage_sum;

  // Pointers carry a wrap bit, so the difference spans 0..Depth inclusive.
  assign ram_level = wptr_q - rptr_q;
  assign wr_ready  = (ram_level != Depth);
  assign push      = wr_valid & wr_ready;
  assign rd_valid  = (occ_q != 2'd0);
  assign rd_data   = ent_q[head_q];
  assign pop       = rd_valid & rd_ready;

  assign ram_we_a  = push;
  assign ram_adr_a = wptr_q[ADDR_WIDTH-1:0];
  assign ram_d_a   = wr_data;
  assign ram_adr_b = rptr_q[ADDR_WIDTH-1:0];
  assign ram_we_b  = 1'b0;

  // Only fetch when the stage is guaranteed a free slot by the time the word lands.
  assign stage_sum = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue     = (ram_level != '0) && (stage_sum < (3'd2 + {2'b00, pop}));

  // A landing word always finds occ <= 1, so the tail is head or its partner.
  assign tail_idx  = head_q ^ occ_q[0];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    head_d     = head_q;
    ent_d      = ent_q;
    inflight_d = issue;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (issue) rptr_d = rptr_q + PtrW'(1);
    if (inflight_q) ent_d[tail_idx] = ram_q_b;
    if (pop) head_d = ~head_q;
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    // Fetch and capture only move words between RAM, flight and stage.
    fill_d = fill_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      fill_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      ent_q      <= ent_d;
      fill_q     <= fill_d;
    end
  end

  assign fill_count = fill_q;

`ifdef VERSATILE_FIFO_ALMOST_FLAGS_EN
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  always_comb begin
    afull_d  = (fill_d >= CntW'(AFULL_LEVEL));
    aempty_d = (fill_d <= CntW'(AEMPTY_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`else
  // Thresholds are only consumed by the flag logic.
  logic unused_levels;
  assign unused_levels = ^{AFULL_LEVEL, AEMPTY_LEVEL};
  assign almost_full   = 1'b0;
  assign almost_empty  = 1'b0;
`endif

endmodule

// File: tb/tb_versatile_fifo_sc_ram_ctrl.sv
// Bench for versatile_fifo_sc_ram_ctrl: behavioural RAM, scoreboard queue fed on
// accepted writes, and a negedge monitor that checks every presented read word.
module tb_versatile_fifo_sc_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [10:0] fill_count;
  logic       almost_full;
  logic       almost_empty;
  logic [8:0] ram_adr_a;
  logic [7:0] ram_d_a;
  logic       ram_we_a;
  logic [8:0] ram_adr_b;
  logic       ram_we_b;
  logic [7:0] ram_q_b;

  versatile_fifo_sc_ram_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .fill_count  (fill_count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .ram_adr_a   (ram_adr_a),
    .ram_d_a     (ram_d_a),
    .ram_we_a    (ram_we_a),
    .ram_adr_b   (ram_adr_b),
    .ram_we_b    (ram_we_b),
    .ram_q_b     (ram_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-port RAM with registered read.
  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         model_fill = 0;
  logic [8:0] wr_addr_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    chk("ram_we_b", 32'(ram_we_b), 32'd0);
    if (!rst_n) begin
      exp_q.delete();
      model_fill    = 0;
      wr_addr_model = '0;
    end else begin
      chk("fill_count", 32'(fill_count), 32'(model_fill));
`ifdef VERSATILE_FIFO_ALMOST_FLAGS_EN
      chk("almost_full", 32'(almost_full), 32'(model_fill >= 510));
      chk("almost_empty", 32'(almost_empty), 32'(model_fill <= 2));
`else
      chk("almost_full_tied", 32'(almost_full), 32'd0);
      chk("almost_empty_tied", 32'(almost_empty), 32'd0);
`endif
      chk("ram_we_a", 32'(ram_we_a), 32'(wr_valid && wr_ready));
      if (ram_we_a) begin
        chk("ram_adr_a", 32'(ram_adr_a), 32'(wr_addr_model));
        wr_addr_model = wr_addr_model + 9'd1;
      end
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
        else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      model_fill = model_fill + int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (fill_count == 0) break;
    end
    @(negedge clk);
    chk({name, "_fill"}, 32'(fill_count), 32'd0);
    chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  int         acc;
  int         gaps;
  bit         seen;
  logic [7:0] nxt;

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_hold_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_hold_fill", 32'(fill_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_fill", 32'(fill_count), 32'd0);
`ifdef VERSATILE_FIFO_ALMOST_FLAGS_EN
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`else
    chk("rst_almost_empty", 32'(almost_empty), 32'd0);
`endif

    // Single word: cycle 0 write, rd_valid in cycle 3
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("single_we_a", 32'(ram_we_a), 32'd1);
    chk("single_adr_a", 32'(ram_adr_a), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("single_c1_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("single_c2_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("single_c3_rd_valid", 32'(rd_valid), 32'd1);
    chk("single_c3_rd_data", 32'(rd_data), 32'hA5);
    @(negedge clk);
    chk("single_fill_after_pop", 32'(fill_count), 32'd0);

    // Fill with consumer stalled
    acc = 0;
    nxt = 8'h10;
    for (int i = 0; i < 530; i++) begin
      @(posedge clk); #1;
      rd_ready = 1'b0;
      wr_valid = 1'b1;
      wr_data  = nxt;
      @(negedge clk);
      if (wr_ready) begin
        acc++;
        nxt = nxt + 8'd1;
      end
    end
    chk("fill_accepted", 32'(acc), 32'd514);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_count_full", 32'(fill_count), 32'd514);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (wr_ready) seen = 1'b1;
    end
    chk("fill_wr_ready_recover", 32'(seen), 32'd1);
    drain("fill_drain");

    // Streaming: 2000 words, no gaps after the initial latency
    gaps = 0;
    acc  = 0;
    for (int i = 0; i < 2003; i++) begin
      @(posedge clk); #1;
      rd_ready = 1'b1;
      wr_valid = (i < 2000);
      wr_data  = 8'(i * 7 + 1);
      @(negedge clk);
      if (wr_valid && wr_ready) acc++;
      if (i >= 3 && !rd_valid) gaps++;
    end
    chk("stream_accepted", 32'(acc), 32'd2000);
    chk("stream_gaps", 32'(gaps), 32'd0);
    drain("stream_drain");

    // Random backpressure
    acc = 0;
    nxt = 8'h33;
    for (int i = 0; i < 1500 && acc < 300; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_data  = nxt;
      rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (wr_ready) begin
        acc++;
        nxt = nxt + 8'd3;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd300);
    drain("bp_drain");

    // Mid-operation reset with a fetch in flight
    acc = 0;
    nxt = 8'h80;
    for (int i = 0; i < 200 && acc < 101; i++) begin
      @(posedge clk); #1;
      rd_ready = 1'b0;
      wr_valid = 1'b1;
      wr_data  = nxt;
      @(negedge clk);
      if (wr_ready) begin
        acc++;
        nxt = nxt + 8'd1;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("mrst_pre_fill", 32'(fill_count), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mrst_fill", 32'(fill_count), 32'd0);
    chk("mrst_wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        seen = 1'b1;
        chk("mrst_readback", 32'(rd_data), 32'h3C);
        break;
      end
    end
    chk("mrst_readback_seen", 32'(seen), 32'd1);
    drain("mrst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
